perceptron_seq_mac: RTL and testbench
=====================================

Name: perceptron_seq_mac

Overview:
- Parametrised N-input perceptron neuron. Replaces the fixed 2-input, dual-multiplier neuron with a single time-multiplexed approximate multiplier-accumulator.
- Computes act(sum_i x_i*w_i + bias) with a selectable per-transaction activation.
- Uses valid/ready handshakes so neurons can be chained or fed by a layer controller.

Parameters:
- N_INPUTS, 4, number of input/weight pairs (>=1).
- DATA_W, 8, width of each input, weight and bias (even, >=4).
- OUT_W, 16, width of output_neuron.
- APPROX_EN, 1, 1 = approximate low-quadrant product; 0 = exact multiply.
- STEP_THRESH, 0, step activation outputs 1 when acc > STEP_THRESH.
- RELU_SHIFT, 4, right shift applied in scaled mode.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- inputs_flat  in  N_INPUTS*DATA_W  x_i at bits [i*DATA_W +: DATA_W].
- weights_flat  in  N_INPUTS*DATA_W  w_i, same packing.
- bias  in  DATA_W  unsigned bias.
- act_mode  in  2  00 linear-saturate, 01 step, 10 shift-saturate, 11 reserved (treated as 00).
- out_valid  out  1  output_neuron valid.
- out_ready  in  1  downstream accepts the result.
- output_neuron  out  OUT_W  activated result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: state=IDLE; in_ready=1 after reset; out_valid=0; output_neuron=0; busy=0; acc=0; idx=0.
- Arithmetic: all unsigned. ACC_W = 2*DATA_W + clog2(N_INPUTS+1). bias is zero-extended.
- Approx product, with H=DATA_W/2 and A=AH:AL, B=BH:BL split into halves:
  - p = (AH*BH << DATA_W) + ((AH*BL + AL*BH) << H) + LL.
  - APPROX_EN=1: LL = bitwise OR over j<H of ((AL & {H{BL[j]}}) << j).
  - APPROX_EN=0: LL = AL*BL, so p is the exact product.
- FSM states: IDLE, MAC, ACT, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch inputs_flat, weights_flat and act_mode; set acc=bias and idx=0; go to MAC. Port changes after acceptance have no effect.
  - MAC: each cycle acc += p(x_idx, w_idx) and idx++. After the idx=N_INPUTS-1 addition, go to ACT. Exactly N_INPUTS cycles.
  - ACT, one cycle; the result is registered into output_neuron:
    - 00: min(acc, 2^OUT_W-1).
    - 01: (acc > STEP_THRESH) ? 1 : 0.
    - 10: min(acc >> RELU_SHIFT, 2^OUT_W-1).
    - Then set out_valid=1 and go to DONE.
  - DONE: hold output_neuron and out_valid stable while out_ready=0. On out_ready=1: out_valid=0, go to IDLE. The new bundle is accepted in IDLE, not in the same cycle.
- Latency: acceptance in cycle T gives out_valid=1 in cycle T+N_INPUTS+2. Throughput is one result per N_INPUTS+3 cycles with out_ready tied high.
- in_ready=0 in MAC, ACT and DONE. in_valid there is ignored and not queued.
- Reset asserted in any state aborts the transaction: reset values next cycle, no out_valid pulse.
- The accumulator never wraps: ACC_W covers the worst case N*(2^DATA_W-1)^2 + 2^DATA_W-1. The approximate LL is never larger than the exact product, so the bound still holds.

Decomposition:
- Package perceptron_pkg holds:
  - act_mode encodings ACT_LINEAR, ACT_STEP, ACT_SHIFT;
  - FSM state encoding;
  - a clog2 helper function / ACC_W derivation.
- Sub-module approx_mult_split, parameters DATA_W and APPROX_EN: purely combinational implementation of the product definition above, instantiated once.
- FSM, counter, accumulator and activation stay in the top module.

Test Plan:
- Exact, linear: N=4, APPROX_EN=0, all x=2, w=3, bias=5, act_mode=00 -> output_neuron=29. out_valid rises exactly 6 cycles after acceptance.
- Approx low quadrant: APPROX_EN=1, x0=3, w0=3, other x/w=0, bias=0, mode 00 -> output_neuron=7 (exact would be 9). Same bench with x0=3, w0=5 -> 15, matching exact.
- Saturation and step:
  - all x=w=255, bias=255, mode 00, APPROX_EN=0 -> acc=260355, output_neuron=65535.
  - mode 01, STEP_THRESH=0 -> 1.
  - all operands 0 in mode 01 -> 0.
  - mode 10: acc=29 -> 29>>4 = 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> output_neuron and out_valid stable, in_ready=0, extra in_valid pulses ignored. out_ready=1 -> returns to IDLE, in_ready=1 next cycle.
- Reset mid-MAC: assert reset during the 2nd MAC cycle -> next cycle busy=0, out_valid=0, output_neuron=0, in_ready=1. A following bundle yields the correct, uncorrupted result.
- Back-to-back, randomised: 200 random bundles with random out_ready -> every result matches a reference model of the product definition for both APPROX_EN settings.

Source files
------------

// File: rtl/perceptron_pkg.sv
// perceptron_pkg: activation encodings, FSM states and accumulator width helpers for perceptron_seq_mac
package perceptron_pkg;
    localparam logic [1:0] ACT_LINEAR = 2'b00;
    localparam logic [1:0] ACT_STEP   = 2'b01;
    localparam logic [1:0] ACT_SHIFT  = 2'b10;
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_e;
    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + clog2(n + 1);
    endfunction
endpackage

// File: rtl/approx_mult_split.sv
// approx_mult_split: half-split unsigned multiplier, low quadrant approximated by OR of partial products when APPROX_EN=1
module approx_mult_split #(
    parameter int DATA_W    = 8,
    parameter int APPROX_EN = 1
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [2*DATA_W-1:0] p_o
);
    localparam int H   = DATA_W / 2;
    localparam int P_W = 2 * DATA_W;
    logic [P_W-1:0] ah, al, bh, bl, ll;
    assign ah = P_W'(a_i[DATA_W-1:H]);
    assign al = P_W'(a_i[H-1:0]);
    assign bh = P_W'(b_i[DATA_W-1:H]);
    assign bl = P_W'(b_i[H-1:0]);
    always_comb begin
        ll = '0;
        for (int j = 0; j < H; j++) ll |= (al & {P_W{bl[j]}}) << j;
        if (APPROX_EN == 0) ll = al * bl;
    end
    assign p_o = ((ah * bh) << DATA_W) + ((ah * bl + al * bh) << H) + ll;
endmodule

// File: rtl/perceptron_seq_mac.sv
// perceptron_seq_mac: N-input perceptron, one shared MAC over N cycles, selectable activation, valid/ready in and out
module perceptron_seq_mac
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS    = 4,
    parameter int DATA_W      = 8,
    parameter int OUT_W       = 16,
    parameter int APPROX_EN   = 1,
    parameter int STEP_THRESH = 0,
    parameter int RELU_SHIFT  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_INPUTS*DATA_W-1:0] inputs_flat,
    input  logic [N_INPUTS*DATA_W-1:0] weights_flat,
    input  logic [DATA_W-1:0]          bias,
    input  logic [1:0]                 act_mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           output_neuron,
    output logic                       busy
);
    localparam int ACC_W = acc_width(N_INPUTS, DATA_W);
    localparam int IDX_W = N_INPUTS > 1 ? clog2(N_INPUTS) : 1;
    localparam int MAX_W = ACC_W > OUT_W ? ACC_W : OUT_W;
    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [N_INPUTS*DATA_W-1:0] x_q, x_d, w_q, w_d;
    logic [1:0]                 mode_q, mode_d;
    logic [OUT_W-1:0]           out_q, out_d, act_res;
    logic [2*DATA_W-1:0]        prod;
    logic [MAX_W-1:0]           lin, shf, sat_max;
    logic                       last;
    approx_mult_split #(.DATA_W(DATA_W), .APPROX_EN(APPROX_EN)) u_mult (
        .a_i(x_q[DATA_W*idx_q +: DATA_W]),
        .b_i(w_q[DATA_W*idx_q +: DATA_W]),
        .p_o(prod)
    );
    assign last    = idx_q == IDX_W'(N_INPUTS - 1);
    assign lin     = MAX_W'(acc_q);
    assign shf     = MAX_W'(acc_q >> RELU_SHIFT);
    assign sat_max = MAX_W'({OUT_W{1'b1}});
    assign act_res = mode_q == ACT_STEP  ? OUT_W'(acc_q > ACC_W'(STEP_THRESH)) :
                     mode_q == ACT_SHIFT ? OUT_W'(shf > sat_max ? sat_max : shf) :
                                           OUT_W'(lin > sat_max ? sat_max : lin);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            mode_q  <= ACT_LINEAR;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            w_q     <= w_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
        end
    end
    always_comb begin
        state_d = (state_q == S_IDLE && in_valid)  ? S_MAC  :
                  (state_q == S_MAC && last)       ? S_ACT  :
                  (state_q == S_ACT)               ? S_DONE :
                  (state_q == S_DONE && out_ready) ? S_IDLE : state_q;
    end
    always_comb begin
        idx_d  = idx_q;
        acc_d  = acc_q;
        x_d    = x_q;
        w_d    = w_q;
        mode_d = mode_q;
        out_d  = out_q;
        if (state_q == S_IDLE && in_valid) begin
            x_d    = inputs_flat;
            w_d    = weights_flat;
            mode_d = act_mode;
            acc_d  = ACC_W'(bias);
            idx_d  = '0;
        end
        if (state_q == S_MAC) begin
            acc_d = acc_q + ACC_W'(prod);
            idx_d = idx_q + IDX_W'(1);
        end
        if (state_q == S_ACT) out_d = act_res;
    end
    always_comb begin
        in_ready      = state_q == S_IDLE;
        busy          = state_q != S_IDLE;
        out_valid     = state_q == S_DONE;
        output_neuron = out_q;
    end
endmodule

// File: tb/tb_perceptron_seq_mac.sv
// tb_perceptron_seq_mac: directed and random checks of exact and approximate perceptron instances driven in lockstep
module tb_perceptron_seq_mac;
    logic        clk = 0, reset = 1, in_valid = 0, out_ready = 1;
    logic [31:0] inputs_flat = '0, weights_flat = '0;
    logic [7:0]  bias = '0;
    logic [1:0]  act_mode = '0;
    logic        in_ready_e, out_valid_e, busy_e, in_ready_a, out_valid_a, busy_a;
    logic [15:0] out_e, out_a;
    int          checks = 0, passes = 0;
    always #5 clk = ~clk;
    perceptron_seq_mac #(.APPROX_EN(0)) u_ex (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_e),
        .inputs_flat(inputs_flat), .weights_flat(weights_flat), .bias(bias), .act_mode(act_mode),
        .out_valid(out_valid_e), .out_ready(out_ready), .output_neuron(out_e), .busy(busy_e)
    );
    perceptron_seq_mac #(.APPROX_EN(1)) u_ap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .inputs_flat(inputs_flat), .weights_flat(weights_flat), .bias(bias), .act_mode(act_mode),
        .out_valid(out_valid_a), .out_ready(out_ready), .output_neuron(out_a), .busy(busy_a)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask
    function automatic int prod(input logic [7:0] a, input logic [7:0] b, input bit apx);
        int ah = int'(a[7:4]), al = int'(a[3:0]), bh = int'(b[7:4]), bl = int'(b[3:0]);
        int ll = 0;
        if (!apx) return int'(a) * int'(b);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 4; j++)
                if (k - j >= 0 && k - j < 4)
                    ll |= (((al >> (k - j)) & 1) & ((bl >> j) & 1)) << k;
        return ah * bh * 256 + (ah * bl + al * bh) * 16 + ll;
    endfunction
    function automatic int model(input logic [31:0] xf, input logic [31:0] wf, input logic [7:0] b,
                                 input logic [1:0] m, input bit apx);
        int acc = int'(b);
        for (int i = 0; i < 4; i++) acc += prod(xf[i*8 +: 8], wf[i*8 +: 8], apx);
        if (m == 2'd1) return acc > 0 ? 1 : 0;
        if (m == 2'd2) acc = acc >> 4;
        return acc > 65535 ? 65535 : acc;
    endfunction
    task automatic send(input logic [31:0] xf, input logic [31:0] wf, input logic [7:0] b, input logic [1:0] m);
        inputs_flat  = xf;
        weights_flat = wf;
        bias         = b;
        act_mode     = m;
        in_valid     = 1;
        @(negedge clk);
        in_valid     = 0;
        inputs_flat  = $urandom;
        weights_flat = $urandom;
        bias         = 8'($urandom);
        act_mode     = 2'($urandom);
    endtask
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid_e && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic run(input string tag, input logic [31:0] xf, input logic [31:0] wf, input logic [7:0] b,
                       input logic [1:0] m, input int ee, input int ea);
        int lat;
        send(xf, wf, b, m);
        chk({tag, " busy"}, busy_e, 1);
        chk({tag, " in_ready low"}, in_ready_a, 0);
        wait_out(lat);
        chk({tag, " latency"}, lat, 6);
        chk({tag, " approx valid"}, out_valid_a, 1);
        chk({tag, " exact out"}, out_e, ee);
        chk({tag, " approx out"}, out_a, ea);
        @(negedge clk);
        chk({tag, " back to idle"}, in_ready_e, 1);
        chk({tag, " valid dropped"}, out_valid_e, 0);
    endtask
    initial begin
        logic [31:0] xf, wf;
        logic [7:0]  b;
        logic [1:0]  m;
        int          lat, ee, ea;
        repeat (2) @(negedge clk);
        reset = 0;
        chk("reset in_ready", in_ready_e, 1);
        chk("reset out_valid", out_valid_e, 0);
        chk("reset out", out_e, 0);
        chk("reset busy", busy_e, 0);
        chk("reset approx busy", busy_a, 0);
        chk("reset approx out", out_a, 0);
        run("linear", 32'h02020202, 32'h03030303, 8'd5, 2'b00, 29, 29);
        run("low quad 3x3", 32'h00000003, 32'h00000003, 8'd0, 2'b00, 9, 7);
        run("low quad 3x5", 32'h00000003, 32'h00000005, 8'd0, 2'b00, 15, 15);
        run("saturate", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd255, 2'b00, 65535, 65535);
        run("step high", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd255, 2'b01, 1, 1);
        run("step zero", 32'h00000000, 32'h00000000, 8'd0, 2'b01, 0, 0);
        run("shift", 32'h02020202, 32'h03030303, 8'd5, 2'b10, 1, 1);
        run("reserved", 32'h02020202, 32'h03030303, 8'd5, 2'b11, 29, 29);
        out_ready = 0;
        send(32'h02020202, 32'h03030303, 8'd5, 2'b00);
        wait_out(lat);
        chk("bp latency", lat, 6);
        for (int i = 0; i < 10; i++) begin
            in_valid     = 1'(i & 1);
            inputs_flat  = $urandom;
            weights_flat = $urandom;
            @(negedge clk);
            chk("bp out held", out_e, 29);
            chk("bp valid held", out_valid_e, 1);
            chk("bp in_ready", in_ready_e, 0);
        end
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        chk("bp release in_ready", in_ready_e, 1);
        chk("bp release valid", out_valid_e, 0);
        @(negedge clk);
        chk("bp nothing queued", busy_e, 0);
        send(32'h02020202, 32'h03030303, 8'd5, 2'b00);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("abort busy", busy_e, 0);
        chk("abort valid", out_valid_e, 0);
        chk("abort out", out_e, 0);
        chk("abort in_ready", in_ready_e, 1);
        run("after abort", 32'h04030201, 32'h05050505, 8'd7, 2'b00, 57, 57);
        for (int n = 0; n < 200; n++) begin
            xf = $urandom;
            wf = $urandom;
            b  = 8'($urandom);
            m  = 2'($urandom);
            ee = model(xf, wf, b, m, 0);
            ea = model(xf, wf, b, m, 1);
            send(xf, wf, b, m);
            wait_out(lat);
            chk("rnd latency", lat, 6);
            out_ready = 0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk("rnd exact", out_e, ee);
            chk("rnd approx", out_a, ea);
            out_ready = 1;
            @(negedge clk);
            chk("rnd idle", in_ready_a, 1);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
